// File: rtl/lynxTypes.sv
// Shared RDMA widths and the ack-pipeline stage record used by the RTT tracker.
package lynxTypes;

  localparam int unsigned RDMA_PSN_BITS  = 24;
  localparam int unsigned RTT_TS_BITS    = 32;
  localparam int unsigned RTT_DEPTH_BITS = 6;

  typedef struct packed {
    logic                      valid;
    logic [RTT_DEPTH_BITS-1:0] idx;
    logic [RTT_TS_BITS-1:0]    sample_ts;
  } ack_stage_t;

endpackage

// File: rtl/rdma_ts_ram.sv
// Timestamp table: one write port, one read port. The read address arrives already
// registered from the ack pipeline stage, so the read is synchronous to the ACK.
module rdma_ts_ram #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 aclk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rdma_rtt_tracker.sv
// Per-PSN transmit timestamping, window gating and cumulative-ACK RTT measurement
// feeding the SWIFT congestion controller.
module rdma_rtt_tracker
  import lynxTypes::*;
#(
  parameter int unsigned PSN_BITS   = RDMA_PSN_BITS,
  parameter int unsigned DEPTH_BITS = RTT_DEPTH_BITS,
  parameter int unsigned TS_BITS    = RTT_TS_BITS
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [PSN_BITS-1:0]   tx_psn,
  input  logic                  ack_valid,
  input  logic [PSN_BITS-1:0]   ack_psn,
  input  logic [31:0]           cwnd,
  output logic [TS_BITS-1:0]    rtt,
  output logic                  ack_event,
  output logic [DEPTH_BITS:0]   inflight,
  output logic                  stale_ack,
  output logic                  seq_err
);

  localparam int unsigned CNT_BITS = DEPTH_BITS + 1;
  localparam logic [CNT_BITS-1:0] MAX_WIN = CNT_BITS'(2**DEPTH_BITS);

  logic [TS_BITS-1:0]  ts_cnt_q;
  logic [CNT_BITS-1:0] inflight_q, inflight_d, win;
  logic [PSN_BITS-1:0] oldest_q, oldest_d, next_psn, ack_dist;
  logic                tx_fire, ack_ok, seq_err_d;
  logic [TS_BITS-1:0]  rtt_q, rd_ts;
  logic                ack_event_q, stale_q, seq_err_q;
  ack_stage_t          stage_d, stage_q;

  always_comb begin
    if (cwnd == 32'd0) begin
      win = CNT_BITS'(1);
    end else if (cwnd >= 32'(MAX_WIN)) begin
      win = MAX_WIN;
    end else begin
      win = cwnd[CNT_BITS-1:0];
    end
  end

  assign tx_ready = inflight_q < win;
  assign tx_fire  = tx_valid && tx_ready;
  assign next_psn = oldest_q + PSN_BITS'(inflight_q);
  assign ack_dist = ack_psn - oldest_q;
  assign ack_ok   = ack_valid && (inflight_q != '0) && (ack_dist < PSN_BITS'(inflight_q));
  assign seq_err_d = tx_fire && (inflight_q != '0) && (tx_psn != next_psn);

  always_comb begin
    inflight_d = inflight_q;
    oldest_d   = oldest_q;
    if (tx_fire) begin
      inflight_d = inflight_d + CNT_BITS'(1);
      if (inflight_q == '0) oldest_d = tx_psn;
    end
    // ack_dist < inflight here, so its low CNT_BITS bits hold the whole distance
    if (ack_ok) begin
      inflight_d = inflight_d - ack_dist[CNT_BITS-1:0] - CNT_BITS'(1);
      oldest_d   = ack_psn + PSN_BITS'(1);
    end
  end

  always_comb begin
    stage_d           = '0;
    stage_d.valid     = ack_ok;
    stage_d.idx       = ack_psn[DEPTH_BITS-1:0];
    stage_d.sample_ts = ts_cnt_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ts_cnt_q    <= '0;
      inflight_q  <= '0;
      oldest_q    <= '0;
      stage_q     <= '0;
      rtt_q       <= '0;
      ack_event_q <= 1'b0;
      stale_q     <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      ts_cnt_q    <= ts_cnt_q + TS_BITS'(1);
      inflight_q  <= inflight_d;
      oldest_q    <= oldest_d;
      stage_q     <= stage_d;
      ack_event_q <= stage_q.valid;
      if (stage_q.valid) rtt_q <= stage_q.sample_ts - rd_ts;
      stale_q     <= ack_valid && !ack_ok;
      seq_err_q   <= seq_err_q | seq_err_d;
    end
  end

  rdma_ts_ram #(
    .ADDR_BITS (DEPTH_BITS),
    .DATA_BITS (TS_BITS)
  ) u_ts_ram (
    .aclk    (aclk),
    .wr_en   (tx_fire),
    .wr_addr (tx_psn[DEPTH_BITS-1:0]),
    .wr_data (ts_cnt_q),
    .rd_addr (stage_q.idx),
    .rd_data (rd_ts)
  );

  assign rtt       = rtt_q;
  assign ack_event = ack_event_q;
  assign inflight  = inflight_q;
  assign stale_ack = stale_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_rdma_rtt_tracker.sv
// Directed bench for rdma_rtt_tracker: window gating, RTT latency/value, stale ACKs,
// PSN wrap, same-cycle TX/ACK, full-depth window, seq_err and mid-pipeline reset.
module tb_rdma_rtt_tracker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [23:0] tx_psn = '0;
  logic        ack_valid = 1'b0;
  logic [23:0] ack_psn = '0;
  logic [31:0] cwnd = 32'd1;
  logic [31:0] rtt;
  logic        ack_event;
  logic [6:0]  inflight;
  logic        stale_ack;
  logic        seq_err;

  int checks = 0;
  int failures = 0;

  rdma_rtt_tracker dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_psn    (tx_psn),
    .ack_valid (ack_valid),
    .ack_psn   (ack_psn),
    .cwnd      (cwnd),
    .rtt       (rtt),
    .ack_event (ack_event),
    .inflight  (inflight),
    .stale_ack (stale_ack),
    .seq_err   (seq_err)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    aresetn = 1'b1;
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_rtt", rtt, 32'd0);
    check("rst_ack_event", 32'(ack_event), 32'd0);
    check("rst_stale", 32'(stale_ack), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);

    // cwnd=1: single packet, ack 15 cycles later
    tx_valid = 1'b1; tx_psn = 24'd100;
    step();
    tx_valid = 1'b0;
    check("w1_tx_ready", 32'(tx_ready), 32'd0);
    check("w1_inflight", 32'(inflight), 32'd1);
    repeat (14) step();
    ack_valid = 1'b1; ack_psn = 24'd100;
    step();
    ack_valid = 1'b0;
    check("w1_ev_lat1", 32'(ack_event), 32'd0);
    check("w1_inflight_ack", 32'(inflight), 32'd0);
    check("w1_tx_ready_ack", 32'(tx_ready), 32'd1);
    step();
    check("w1_ev_lat2", 32'(ack_event), 32'd1);
    check("w1_rtt", rtt, 32'd15);
    step();
    check("w1_ev_pulse", 32'(ack_event), 32'd0);
    check("w1_rtt_hold", rtt, 32'd15);

    // cwnd=4: psn 5..8, cumulative ack of 7 after 18 cycles from its send
    cwnd = 32'd4;
    tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_psn = 24'(5 + i);
      step();
    end
    tx_valid = 1'b0;
    check("w4_inflight", 32'(inflight), 32'd4);
    check("w4_tx_ready", 32'(tx_ready), 32'd0);
    repeat (16) step();
    ack_valid = 1'b1; ack_psn = 24'd7;
    step();
    ack_valid = 1'b0;
    check("w4_inflight_ack", 32'(inflight), 32'd1);
    check("w4_ev_lat1", 32'(ack_event), 32'd0);
    step();
    check("w4_ev", 32'(ack_event), 32'd1);
    check("w4_rtt", rtt, 32'd18);
    ack_valid = 1'b1; ack_psn = 24'd7;
    step();
    ack_valid = 1'b0;
    check("dup_stale", 32'(stale_ack), 32'd1);
    check("dup_inflight", 32'(inflight), 32'd1);
    check("dup_no_ev", 32'(ack_event), 32'd0);
    step();
    check("dup_stale_pulse", 32'(stale_ack), 32'd0);
    check("dup_no_ev2", 32'(ack_event), 32'd0);

    // Same-cycle TX psn 9 and ACK psn 8, then back-to-back ack of 9
    tx_valid = 1'b1; tx_psn = 24'd9;
    ack_valid = 1'b1; ack_psn = 24'd8;
    step();
    tx_valid = 1'b0; ack_psn = 24'd9;
    check("sc_inflight", 32'(inflight), 32'd1);
    check("sc_tx_ready", 32'(tx_ready), 32'd1);
    step();
    ack_valid = 1'b0;
    check("sc_ev8", 32'(ack_event), 32'd1);
    check("sc_inflight_ack9", 32'(inflight), 32'd0);
    check("sc_ack9_valid", 32'(stale_ack), 32'd0);
    step();
    check("sc_ev9_b2b", 32'(ack_event), 32'd1);
    check("sc_rtt9", rtt, 32'd1);
    check("sc_seq_ok", 32'(seq_err), 32'd0);

    // cwnd=0 behaves as a window of one
    cwnd = 32'd0;
    #1;
    check("c0_tx_ready", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1; tx_psn = 24'd50;
    step();
    check("c0_tx_ready_full", 32'(tx_ready), 32'd0);
    check("c0_inflight", 32'(inflight), 32'd1);
    tx_psn = 24'd51;
    step();
    tx_valid = 1'b0;
    check("c0_blocked", 32'(inflight), 32'd1);
    ack_valid = 1'b1; ack_psn = 24'd50;
    step();
    ack_valid = 1'b0;
    check("c0_inflight_ack", 32'(inflight), 32'd0);
    step();
    check("c0_ev", 32'(ack_event), 32'd1);
    check("c0_rtt", rtt, 32'd2);

    // PSN wrap
    cwnd = 32'd4;
    tx_valid = 1'b1;
    tx_psn = 24'hFFFFFE; step();
    tx_psn = 24'hFFFFFF; step();
    tx_psn = 24'h000000; step();
    tx_valid = 1'b0;
    check("wrap_inflight", 32'(inflight), 32'd3);
    check("wrap_seq_ok", 32'(seq_err), 32'd0);
    repeat (4) step();
    ack_valid = 1'b1; ack_psn = 24'h000000;
    step();
    ack_valid = 1'b0;
    check("wrap_inflight_ack", 32'(inflight), 32'd0);
    check("wrap_ack_valid", 32'(stale_ack), 32'd0);
    step();
    check("wrap_ev", 32'(ack_event), 32'd1);
    check("wrap_rtt", rtt, 32'd5);
    ack_valid = 1'b1; ack_psn = 24'h000005;
    step();
    ack_valid = 1'b0;
    check("empty_stale", 32'(stale_ack), 32'd1);
    check("empty_no_ev", 32'(ack_event), 32'd0);
    check("empty_inflight", 32'(inflight), 32'd0);

    // Large cwnd is capped by table depth
    cwnd = 32'd1000;
    tx_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tx_psn = 24'(200 + i);
      if (i == 63) check("cap_ready_at_63", 32'(tx_ready), 32'd1);
      step();
    end
    tx_psn = 24'd264;
    check("cap_inflight", 32'(inflight), 32'd64);
    check("cap_tx_ready", 32'(tx_ready), 32'd0);
    step();
    tx_valid = 1'b0;
    check("cap_blocked", 32'(inflight), 32'd64);
    cwnd = 32'd10;
    ack_valid = 1'b1; ack_psn = 24'd263;
    step();
    ack_valid = 1'b0;
    check("cap_inflight_ack", 32'(inflight), 32'd0);
    check("cap_seq_ok", 32'(seq_err), 32'd0);
    step();
    check("cap_ev", 32'(ack_event), 32'd1);
    check("cap_rtt", rtt, 32'd2);

    // Non-contiguous PSN, then reset right behind a valid ACK
    cwnd = 32'd4;
    tx_valid = 1'b1;
    tx_psn = 24'd20; step();
    tx_psn = 24'd22; step();
    tx_valid = 1'b0;
    check("seq_err_set", 32'(seq_err), 32'd1);
    check("seq_inflight", 32'(inflight), 32'd2);
    ack_valid = 1'b1; ack_psn = 24'd21;
    step();
    ack_valid = 1'b0;
    aresetn = 1'b0;
    check("seq_inflight_ack", 32'(inflight), 32'd0);
    check("seq_err_sticky", 32'(seq_err), 32'd1);
    step();
    check("mrst_no_ev", 32'(ack_event), 32'd0);
    check("mrst_rtt", rtt, 32'd0);
    check("mrst_inflight", 32'(inflight), 32'd0);
    check("mrst_seq_err", 32'(seq_err), 32'd0);
    check("mrst_stale", 32'(stale_ack), 32'd0);
    check("mrst_tx_ready", 32'(tx_ready), 32'd1);
    step();
    aresetn = 1'b1;
    check("mrst_no_ev2", 32'(ack_event), 32'd0);
    step();
    check("post_rst_no_ev", 32'(ack_event), 32'd0);
    check("post_rst_rtt", rtt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
